dmem_burst_master: RTL and testbench

DMEM_BURST_MASTER -- requirements
Module: dmem_burst_master

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_burst_master.sv | 119 +++++++++++
 tb/tb_dmem_burst_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory burst master.
// Holds the FSM encoding and the byte-address step/wrap rules.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_HOLD,
    WR_WAIT,
    WR_ISSUE,
    DONE
  } state_t;

  localparam logic [7:0] ADDR_STEP      = 8'd4;
  localparam logic [7:0] ADDR_WRAP_MASK = 8'hFF;

  // Only the low byte moves; the upper bits stay at the burst base.
  function automatic logic [31:0] next_addr(
    input logic [31:0] a
  );
    logic [7:0] lo;
    lo = (a[7:0] + ADDR_STEP) & ADDR_WRAP_MASK;
    return {a[31:8], lo};
  endfunction

endpackage

// File: rtl/dmem_burst_master.sv
// Burst master moving words between a valid/ready stream and a
// single-cycle data memory, two cycles per word when unstalled.
module dmem_burst_master
  import dmem_pkg::*;
#(
  parameter int MAX_WORDS = 32
) (
  input  logic        clock,
  input  logic        clr,
  input  logic        start,
  input  logic        dir,
  input  logic [31:0] base_addr,
  input  logic [5:0]  count,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        we,
  input  logic [31:0] dataout
);

  localparam logic [6:0] MAX_W = 7'(MAX_WORDS);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] remaining;
  logic       bad_req;
  logic       last_word;

  assign bad_req = (base_addr[1:0] != 2'b00) ||
                   ({1'b0, count} > MAX_W);
  assign last_word = (remaining == 6'd1);

  always_ff @(posedge clock or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    we        = (state == WR_ISSUE);
    rd_valid  = (state == RD_HOLD);
    wr_ready  = (state == WR_WAIT);
    unique case (state)
      IDLE: begin
        if (start) begin
          if (bad_req || count == 6'd0)
            state_nxt = DONE;
          else if (dir)
            state_nxt = WR_WAIT;
          else
            state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_HOLD;
      RD_HOLD: begin
        if (rd_ready)
          state_nxt = last_word ? DONE : RD_ISSUE;
      end
      WR_WAIT: begin
        if (wr_valid) state_nxt = WR_ISSUE;
      end
      WR_ISSUE: state_nxt = last_word ? DONE : WR_WAIT;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Address, count and data registers follow the FSM state.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      addr      <= '0;
      datain    <= '0;
      rd_data   <= '0;
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (bad_req) begin
              err <= 1'b1;
            end else begin
              err       <= 1'b0;
              addr      <= base_addr;
              remaining <= count;
            end
          end
        end
        RD_ISSUE: rd_data <= dataout;
        RD_HOLD: begin
          if (rd_ready) begin
            remaining <= remaining - 6'd1;
            addr      <= next_addr(addr);
          end
        end
        WR_WAIT: begin
          if (wr_valid) datain <= wr_data;
        end
        WR_ISSUE: begin
          remaining <= remaining - 6'd1;
          addr      <= next_addr(addr);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_burst_master.sv
// Randomized bench for dmem_burst_master against a transfer-list
// model built from the base address, count and source data.
module tb_dmem_burst_master;

  logic        clock = 1'b0;
  logic        clr;
  logic        start;
  logic        dir;
  logic [31:0] base_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;

  logic [31:0] mem [64];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign dataout = mem[addr[7:2]];

  dmem_burst_master #(.MAX_WORDS(32)) dut (
    .clock     (clock),
    .clr       (clr),
    .start     (start),
    .dir       (dir),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .addr      (addr),
    .datain    (datain),
    .we        (we),
    .dataout   (dataout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"},
        {26'b0, we, done, err, rd_valid, wr_ready, busy}, 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_datain"}, datain, 32'h0);
    chk({tag, "_rd_data"}, rd_data, 32'h0);
  endtask

  // stall: 0 = stream never stalls, 1 = random stalls,
  // 2 = rd_ready held low for the first five hold cycles
  task automatic run_burst(input logic        d,
                           input logic [31:0] base,
                           input logic [5:0]  cnt,
                           input int          stall,
                           input logic [31:0] w0,
                           input logic [31:0] w1);
    logic [31:0] src [40];
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];
    logic [31:0] got_a [$];
    logic [31:0] got_d [$];
    logic [31:0] a;
    logic [31:0] hold_d;
    logic [31:0] hold_a;
    logic [31:0] r;
    logic [7:0]  lo;
    logic        rej;
    logic        holding;
    logic        prev_we;
    int          src_idx;
    int          cyc;
    int          done_cyc;
    int          nx;

    rej = (base[1:0] != 2'b00) || (cnt > 6'd32);
    for (int i = 0; i < 40; i++) src[i] = $urandom;
    src[0] = w0;
    src[1] = w1;
    if (!rej) begin
      for (int i = 0; i < int'(cnt); i++) begin
        lo = 8'((int'(base[7:0]) + 4 * i) % 256);
        a  = {base[31:8], lo};
        exp_a.push_back(a);
        exp_d.push_back(d ? src[i] : mem[a[7:2]]);
      end
    end

    @(posedge clock); #1;
    start     = 1'b1;
    dir       = d;
    base_addr = base;
    count     = cnt;
    rd_ready  = (stall == 1) ? 1'($urandom_range(0, 1))
                             : (stall == 0);
    wr_valid  = (stall == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_data   = src[0];

    src_idx  = 0;
    cyc      = 0;
    done_cyc = -1;
    holding  = 1'b0;
    prev_we  = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clock);
      if (holding && rd_valid) begin
        chk("rd_hold_data", rd_data, hold_d);
        chk("rd_hold_addr", addr, hold_a);
      end
      holding = rd_valid && !rd_ready;
      hold_d  = rd_data;
      hold_a  = addr;
      chk("excl", {31'b0, (we && (rd_valid || wr_ready)) ||
                          (rd_valid && wr_ready)}, 32'h0);
      if (we) begin
        chk("we_pulse", {31'b0, prev_we || !d}, 32'h0);
        got_a.push_back(addr);
        got_d.push_back(datain);
        mem[addr[7:2]] = datain;
      end
      if (rd_valid && rd_ready) begin
        got_a.push_back(addr);
        got_d.push_back(rd_data);
      end
      if (wr_valid && wr_ready && src_idx < 39) src_idx++;
      if (done) begin
        done_cyc = cyc;
        chk("err_at_done", {31'b0, err}, {31'b0, rej});
        chk("busy_at_done", {31'b0, busy}, 32'h1);
      end
      prev_we = we;

      @(posedge clock); #1;
      cyc++;
      r         = $urandom;
      start     = busy && !done && (r[1:0] == 2'b00);
      dir       = r[2];
      base_addr = {r[31:8], 8'h44};
      count     = 6'd5;
      if (stall == 1) begin
        rd_ready = 1'($urandom_range(0, 1));
        wr_valid = 1'($urandom_range(0, 1));
      end else if (stall == 2) begin
        rd_ready = (cyc >= 7);
      end
      wr_data = src[src_idx];
    end
    start = 1'b0;

    chk("done_seen", {31'b0, done_cyc >= 0}, 32'h1);
    chk("n_xfer", got_a.size(), exp_a.size());
    nx = (got_a.size() < exp_a.size()) ? got_a.size()
                                       : exp_a.size();
    for (int i = 0; i < nx; i++) begin
      chk("xfer_addr", got_a[i], exp_a[i]);
      chk("xfer_data", got_d[i], exp_d[i]);
    end
    if (stall == 0)
      chk("latency", done_cyc,
          (rej || cnt == 6'd0) ? 1 : 2 * int'(cnt) + 1);
    @(negedge clock);
    chk("done_pulse", {30'b0, done, busy}, 32'h0);
    chk("err_sticky", {31'b0, err}, {31'b0, rej});
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] base;
    logic [5:0]  cnt;
    int          cyc;

    clr       = 1'b1;
    start     = 1'b0;
    dir       = 1'b0;
    base_addr = '0;
    count     = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    #12;
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    clr = 1'b0;

    mem[4] = 32'hA;
    mem[5] = 32'hB;
    mem[6] = 32'hC;
    run_burst(1'b0, 32'h0000_0010, 6'd3, 0, 0, 0);
    run_burst(1'b1, 32'h0000_007C, 6'd2, 0, 32'h11, 32'h22);
    run_burst(1'b1, 32'hABCD_12FC, 6'd2, 0, 32'h33, 32'h44);
    run_burst(1'b0, 32'h0000_0040, 6'd2, 2, 0, 0);
    run_burst(1'b1, 32'h0000_0002, 6'd2, 0, 0, 0);
    run_burst(1'b1, 32'h0000_0020, 6'd33, 0, 0, 0);
    run_burst(1'b1, 32'h0000_0020, 6'd0, 0, 0, 0);
    run_burst(1'b0, 32'h0000_0080, 6'd32, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      r    = $urandom;
      base = {r[31:8], r[7:2], 2'b00};
      if (r[4:0] == 5'd3) base[1:0] = r[9:8] | 2'b01;
      cnt  = 6'($urandom_range(0, 34));
      run_burst(r[5], base, cnt, int'(r[6]), $urandom, $urandom);
    end

    // Reset during the first write strobe of a burst.
    @(posedge clock); #1;
    start     = 1'b1;
    dir       = 1'b1;
    base_addr = 32'h0000_1240;
    count     = 6'd4;
    wr_valid  = 1'b1;
    wr_data   = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    start = 1'b0;
    cyc   = 0;
    @(negedge clock);
    while (!we && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("we_before_clr", {31'b0, we}, 32'h1);
    #2;
    clr = 1'b1;
    #1;
    chk_reset_outputs("clr_mid_write");
    repeat (2) begin
      @(negedge clock);
      chk("clr_hold", {29'b0, done, busy, we}, 32'h0);
    end
    @(posedge clock); #1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("post_clr_idle", {29'b0, done, busy, we}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
